pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Sequencing controller for the 3-stage pipeline (FD → EM → MW). It drives the data-memory request handshake for the load/store in EM and stalls FD/EM across memory wait states. It inserts a bubble on load-use hazards and defers branch/mret flushes that arrive during a stall. The forwarding logic consumes its `stall_*`/`flush_FD` outputs in place of the fixed no-stall assumption. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `Width`, 32, instruction/counter width
- `TimeoutCycles`, 255, max MEM_WAIT cycles before abort (≥1, fits 8 bits)

- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ir_FD`  in  Width  instruction in FD (rs1=[19:15], rs2=[24:20])
- `ir_EM`  in  Width  instruction in EM (rd=[11:7])
- `is_load_EM`  in  1  EM holds a load
- `is_store_EM`  in  1  EM holds a store
- `br_taken`  in  1  branch/jump resolved taken in EM
- `is_mret`  in  1  mret in EM
- `dmem_ack`  in  1  data memory completes current access this cycle
- `dmem_req`  out  1  data memory access request
- `stall_FD`  out  1  hold FD register/PC
- `stall_EM`  out  1  hold EM register
- `bubble_EM`  out  1  load NOP into EM at next edge
- `flush_FD`  out  1  squash FD instruction
- `err_timeout`  out  1  one-cycle pulse, access aborted
- `stall_cnt`  out  Width  cycles with stall_FD=1, saturating

## Operation
- `mem_op = is_load_EM | is_store_EM`. Load-use hazard: `hz = is_load_EM && rd!=0 && (rd==rs1 || rd==rs2)`.
- FSM state IDLE:
  - mem_op → dmem_req=1.
  - dmem_ack same cycle → zero-wait, stay IDLE.
  - Else → MEM_WAIT, with stall_FD=stall_EM=1 this cycle.
- FSM state MEM_WAIT:
  - dmem_req=1.
  - No ack → stall_FD=stall_EM=1.
  - dmem_ack → stall_EM=0 and → IDLE. stall_FD=0 unless hz.
- Load-use: in any cycle where the load's dmem_ack=1 and hz=1, stall_FD=1 and bubble_EM=1. The next cycle carries no stall (regfile write-through from MW).
- Flush:
  - flush_FD = (br_taken|is_mret) when stall_EM=0.
  - If br_taken|is_mret arrives while stall_EM=1, set `flush_pend`.
  - flush_FD asserts in the first cycle with stall_EM=0, and flush_pend clears at that edge.
  - flush_FD and bubble_EM may assert together; flush_FD wins over stall_FD for FD contents.
- stall_cnt: +1 each cycle stall_FD=1. It holds at all-ones.
- Timeout (macro): 8-bit `wait_cnt` clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
  - When wait_cnt==TimeoutCycles-1 with no ack: err_timeout=1, dmem_req=0, flush_FD=1, stall_EM=0 (EM retired as NOP by core), then → IDLE.
  - Ack in that same cycle wins; no error.

## Timing
- dmem_req, stall_FD, stall_EM, bubble_EM, flush_FD: combinational from state/flush_pend/inputs (Mealy). Zero-wait accesses cost 0 stall cycles.
- Wait-state access with ack on cycle N (N≥1 after request): stall_FD/stall_EM high for N cycles, plus 1 stall_FD cycle if hz.
- err_timeout: registered? No — combinational pulse in abort cycle; wait_cnt, state, flush_pend, stall_cnt registered.
- Reset (rst_n=0, immediate):
  - state=IDLE, wait_cnt=0, flush_pend=0, stall_cnt=0.
  - All outputs forced 0 while rst_n=0 regardless of inputs.
- Reset mid-MEM_WAIT: request drops immediately. No pending flush survives.
- ir_FD/ir_EM must be stable while stall_* asserted.

## Configuration
- `PIPE_HAZARD_CTRL_TIMEOUT_EN`:
  - Defined: wait_cnt and abort path present as above.
  - Undefined: no wait_cnt; MEM_WAIT lasts until dmem_ack indefinitely; err_timeout tied 0; TimeoutCycles unused.

## Test plan
- Zero-wait: load to x5 in EM, ack same cycle, FD uses x6 → dmem_req=1, stall_FD=stall_EM=0, stall_cnt stays 0.
- 3-wait store: ack on 4th request cycle → stall_FD/EM high 3 cycles, dmem_req high 4 cycles, stall_cnt=3, state IDLE after.
- Load-use: load rd=x7, FD rs2=x7, ack after 2 waits → 2 cycles stall_FD+stall_EM, then ack cycle stall_FD=1, bubble_EM=1, stall_EM=0; stall_cnt=3. Repeat with rd=x0 → no bubble.
- Deferred flush: is_mret pulsed during MEM_WAIT → flush_FD=0 while stalled, flush_FD=1 exactly in ack cycle, 0 after.
- Timeout (macro on, TimeoutCycles=4): no ack → err_timeout=1 and flush_FD=1 on 4th wait cycle, dmem_req=0 that cycle, IDLE next. Macro off: still waiting after 300 cycles, err_timeout=0.
- Async reset during MEM_WAIT with flush_pend=1 → all outputs 0 before next edge; after release, an access with immediate ack produces no flush and stall_cnt=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the hazard/sequencing controller.
// The controller binds to the slave modport; the core (or bench) drives the master side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned Width = 32
);
  logic [Width-1:0] ir_FD;
  logic [Width-1:0] ir_EM;
  logic             is_load_EM;
  logic             is_store_EM;
  logic             br_taken;
  logic             is_mret;
  logic             dmem_ack;
  logic             dmem_req;
  logic             stall_FD;
  logic             stall_EM;
  logic             bubble_EM;
  logic             flush_FD;
  logic             err_timeout;
  logic [Width-1:0] stall_cnt;

  modport master (
    output ir_FD, ir_EM, is_load_EM, is_store_EM, br_taken, is_mret, dmem_ack,
    input  dmem_req, stall_FD, stall_EM, bubble_EM, flush_FD, err_timeout, stall_cnt
  );

  modport slave (
    input  ir_FD, ir_EM, is_load_EM, is_store_EM, br_taken, is_mret, dmem_ack,
    output dmem_req, stall_FD, stall_EM, bubble_EM, flush_FD, err_timeout, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush sequencing for the FD->EM->MW pipeline and the EM data-memory handshake.
// Optional wait-state abort is enabled by defining PIPE_HAZARD_CTRL_TIMEOUT_EN.
module pipe_hazard_ctrl #(
  parameter int unsigned Width         = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StMemWait} state_e;

  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [Width-1:0] stall_cnt_q, stall_cnt_d;

  logic [4:0] rd, rs1, rs2;
  logic       mem_op, hz, redirect, abort;
  logic       req, stall_fd, stall_em, bubble, flush;

  assign rd       = bus.ir_EM[11:7];
  assign rs1      = bus.ir_FD[19:15];
  assign rs2      = bus.ir_FD[24:20];
  assign mem_op   = bus.is_load_EM | bus.is_store_EM;
  assign hz       = bus.is_load_EM && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  assign redirect = bus.br_taken | bus.is_mret;

`ifdef PIPE_HAZARD_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  assign abort = (state_q == StMemWait) && !bus.dmem_ack &&
                 (wait_cnt_q == 8'(TimeoutCycles - 1));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == StIdle && state_d == StMemWait) begin
      wait_cnt_d = 8'd0;
    end else if (state_q == StMemWait && !bus.dmem_ack) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  // TimeoutCycles has no effect without the abort path.
  assign abort = (TimeoutCycles == 0) && 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (mem_op && !bus.dmem_ack) state_d = StMemWait;
      StMemWait: if (bus.dmem_ack || abort) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    stall_fd = 1'b0;
    stall_em = 1'b0;
    bubble   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          req = 1'b1;
          if (!bus.dmem_ack) begin
            stall_fd = 1'b1;
            stall_em = 1'b1;
          end else if (hz) begin
            stall_fd = 1'b1;
            bubble   = 1'b1;
          end
        end
      end
      StMemWait: begin
        if (bus.dmem_ack) begin
          req      = 1'b1;
          stall_fd = hz;
          bubble   = hz;
        end else if (!abort) begin
          req      = 1'b1;
          stall_fd = 1'b1;
          stall_em = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A redirect seen while EM is held is replayed in the first unstalled cycle.
  assign flush        = !stall_em && (redirect || flush_pend_q || abort);
  assign flush_pend_d = stall_em ? (flush_pend_q | redirect) : 1'b0;
  assign stall_cnt_d  = (stall_fd && !(&stall_cnt_q)) ? stall_cnt_q + Width'(1) : stall_cnt_q;

  assign bus.dmem_req    = rst_n & req;
  assign bus.stall_FD    = rst_n & stall_fd;
  assign bus.stall_EM    = rst_n & stall_em;
  assign bus.bubble_EM   = rst_n & bubble;
  assign bus.flush_FD    = rst_n & flush;
  assign bus.err_timeout = rst_n & abort;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
